// File: rtl/grid_display_tx_if.sv
// Display-side bundle of grid_display_tx: grid/update in, serial pins and status out.
interface grid_display_tx_if;
    logic [63:0] grid;
    logic        update;
    logic        busy;
    logic        frame_done;
    logic        sclk;
    logic        mosi;
    logic        cs_n;

    modport master (output grid, update, input busy, frame_done, sclk, mosi, cs_n);
    modport slave  (input grid, update, output busy, frame_done, sclk, mosi, cs_n);
endinterface

// File: rtl/grid_display_tx.sv
// MAX7219-style serial transmitter: 5-word init after reset, then 8 row words per
// update request, with a one-deep pending request chaining frames back to back.
module grid_display_tx #(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic              clk,
    input  logic              rst_n,
    grid_display_tx_if.slave  bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_INIT_SHIFT, S_INIT_GAP, S_IDLE, S_FRAME_SHIFT, S_FRAME_GAP
    } state_t;

    state_t      r_state, w_next_state;
    logic [7:0]  r_div, w_div;
    logic [4:0]  r_half, w_half;
    logic [2:0]  r_widx, w_widx;
    logic [15:0] r_shreg, w_shreg;
    logic [63:0] r_snap, w_snap;
    logic        r_pend, w_pend;
    logic        r_armed, w_armed;
    logic        r_sclk, w_sclk;
    logic        r_mosi, w_mosi;
    logic        r_cs_n, w_cs_n;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        w_load;
    logic [15:0] w_word;

    logic w_div_end, w_shift_end, w_gap_end, w_last, w_pend_eff, w_is_gap;

    function automatic logic [15:0] f_init_word(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'h0C01;
            3'd1:    return 16'h0B07;
            3'd2:    return 16'h0900;
            3'd3:    return {12'h0A0, INTENSITY};
            default: return 16'h0F00;
        endcase
    endfunction

    // Column 0 of a row is transmitted first, so it lands in the data MSB.
    function automatic logic [15:0] f_row_word(input logic [63:0] snap, input logic [2:0] row);
        logic [7:0] d;
        d = '0;
        for (int c = 0; c < 8; c++) d[7-c] = snap[{row, 3'(c)}];
        return {4'h0, {1'b0, row} + 4'd1, d};
    endfunction

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_shift_end = w_div_end && (r_half == 5'd31);
    assign w_gap_end   = w_div_end && r_half[0];
    assign w_last      = (r_state == S_INIT_GAP) ? (r_widx == 3'd4) : (r_widx == 3'd7);
    assign w_pend_eff  = r_pend | bus.update;
    assign w_is_gap    = (r_state == S_INIT_GAP) || (r_state == S_FRAME_GAP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT_SHIFT;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT_SHIFT:  if (r_armed && w_shift_end) w_next_state = S_INIT_GAP;
            S_FRAME_SHIFT: if (w_shift_end) w_next_state = S_FRAME_GAP;
            S_INIT_GAP, S_FRAME_GAP: begin
                if (w_gap_end) begin
                    if (!w_last)
                        w_next_state = (r_state == S_INIT_GAP) ? S_INIT_SHIFT : S_FRAME_SHIFT;
                    else
                        w_next_state = w_pend_eff ? S_FRAME_SHIFT : S_IDLE;
                end
            end
            S_IDLE:        if (bus.update) w_next_state = S_FRAME_SHIFT;
            default:       w_next_state = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_div   = r_div;
        w_half  = r_half;
        w_widx  = r_widx;
        w_shreg = r_shreg;
        w_snap  = r_snap;
        w_pend  = r_pend;
        w_armed = r_armed;
        w_sclk  = r_sclk;
        w_mosi  = r_mosi;
        w_cs_n  = r_cs_n;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_load  = 1'b0;
        w_word  = 16'h0;

        if (bus.update && r_state != S_IDLE) w_pend = 1'b1;

        case (r_state)
            S_INIT_SHIFT, S_FRAME_SHIFT: begin
                if (!r_armed) begin
                    w_armed = 1'b1;
                    w_busy  = 1'b1;
                    w_widx  = 3'd0;
                    w_load  = 1'b1;
                    w_word  = f_init_word(3'd0);
                end else if (w_div_end) begin
                    w_div  = 8'd0;
                    w_half = r_half + 5'd1;
                    if (!r_half[0]) begin
                        w_sclk = 1'b1;
                    end else begin
                        w_sclk = 1'b0;
                        if (r_half == 5'd31) begin
                            w_cs_n = 1'b1;
                            w_mosi = 1'b0;
                            w_half = 5'd0;
                        end else begin
                            w_mosi  = r_shreg[14];
                            w_shreg = {r_shreg[14:0], 1'b0};
                        end
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_INIT_GAP, S_FRAME_GAP: begin
                // Gap is two divider periods, tracked in bit 0 of the half counter.
                if (w_div_end) begin
                    w_div = 8'd0;
                    if (r_half[0]) begin
                        if (!w_last) begin
                            w_widx = r_widx + 3'd1;
                            w_load = 1'b1;
                            w_word = (r_state == S_INIT_GAP) ? f_init_word(r_widx + 3'd1)
                                                             : f_row_word(r_snap, r_widx + 3'd1);
                        end else begin
                            w_widx = 3'd0;
                            w_done = (r_state == S_FRAME_GAP);
                            if (w_pend_eff) begin
                                w_pend = 1'b0;
                                w_snap = bus.grid;
                                w_load = 1'b1;
                                w_word = f_row_word(bus.grid, 3'd0);
                            end else begin
                                w_busy = 1'b0;
                            end
                        end
                    end else begin
                        w_half = 5'd1;
                    end
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            S_IDLE: begin
                if (bus.update) begin
                    w_snap = bus.grid;
                    w_busy = 1'b1;
                    w_widx = 3'd0;
                    w_load = 1'b1;
                    w_word = f_row_word(bus.grid, 3'd0);
                end
            end
            default: ;
        endcase

        if (w_load) begin
            w_shreg = w_word;
            w_mosi  = w_word[15];
            w_cs_n  = 1'b0;
            w_sclk  = 1'b0;
            w_div   = 8'd0;
            w_half  = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= 8'd0;
            r_half  <= 5'd0;
            r_widx  <= 3'd0;
            r_shreg <= 16'h0;
            r_snap  <= 64'h0;
            r_pend  <= 1'b0;
            r_armed <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_div   <= w_div;
            r_half  <= w_half;
            r_widx  <= w_widx;
            r_shreg <= w_shreg;
            r_snap  <= w_snap;
            r_pend  <= w_pend;
            r_armed <= w_armed;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
            r_cs_n  <= w_cs_n;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.sclk       = r_sclk;
    assign bus.mosi       = r_mosi;
    assign bus.cs_n       = r_cs_n;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

    // w_is_gap documents the gap grouping used by both combinational processes.
    logic w_unused;
    assign w_unused = w_is_gap;

endmodule

// File: tb/tb_grid_display_tx.sv
// Scoreboard bench for grid_display_tx: one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_grid_display_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  rst_n_d = 2'b00;
    logic [1:0]  upd_d   = 2'b00;
    logic [63:0] grid_d [2];
    logic [1:0]  sclk_s, mosi_s, csn_s, busy_s, done_s;

    logic [15:0] exp_w [2][512];
    int wr_p [2];
    int rd_p [2];
    int done_cnt [2];
    int exp_done [2];
    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: row r word is {0, r+1, data}, column c of the row weighted 0x80>>c.
    function automatic logic [15:0] model_row(input logic [63:0] g, input int r);
        logic [7:0] dat;
        dat = 8'h00;
        for (int c = 0; c < 8; c++)
            if (g[r*8 + c]) dat = dat | (8'h80 >> c);
        return {4'h0, 4'(r + 1), dat};
    endfunction

    task automatic push_w(input int d, input logic [15:0] w);
        exp_w[d][wr_p[d] % 512] = w;
        wr_p[d]++;
    endtask

    task automatic push_init(input int d);
        push_w(d, 16'h0C01);
        push_w(d, 16'h0B07);
        push_w(d, 16'h0900);
        push_w(d, 16'h0A08);
        push_w(d, 16'h0F00);
    endtask

    task automatic push_frame(input int d, input logic [63:0] g);
        for (int r = 0; r < 8; r++) push_w(d, model_row(g, r));
    endtask

    for (genvar g = 0; g < 2; g++) begin : G
        localparam int D = (g == 0) ? 4 : 1;
        grid_display_tx_if bus();
        grid_display_tx #(.CLK_DIV(D), .INTENSITY(4'h8)) u_dut (
            .clk   (clk),
            .rst_n (rst_n_d[g]),
            .bus   (bus)
        );
        assign bus.grid   = grid_d[g];
        assign bus.update = upd_d[g];
        assign sclk_s[g]  = bus.sclk;
        assign mosi_s[g]  = bus.mosi;
        assign csn_s[g]   = bus.cs_n;
        assign busy_s[g]  = bus.busy;
        assign done_s[g]  = bus.frame_done;

        logic        pcs, psclk;
        logic [15:0] sh;
        int          nb, fall_c, fstart;

        // Monitor: collect a word per cs_n low window, pop and compare on cs_n rise.
        initial begin
            pcs = 1'b1; psclk = 1'b0; sh = 16'h0; nb = 0; fall_c = 0; fstart = 0;
            forever begin
                @(negedge clk);
                if (!rst_n_d[g]) begin
                    pcs = 1'b1; psclk = 1'b0; nb = 0;
                end else begin
                    if (pcs && !csn_s[g]) begin
                        fall_c = cyc; nb = 0; sh = 16'h0;
                    end
                    if (!csn_s[g] && !psclk && sclk_s[g]) begin
                        sh = {sh[14:0], mosi_s[g]};
                        nb++;
                    end
                    if (!pcs && csn_s[g]) begin
                        chk(cyc - fall_c == 32*D, "cs_low_len", 64'(cyc - fall_c), 64'(32*D));
                        if (rd_p[g] == wr_p[g]) begin
                            chk(1'b0, "unexpected_word", 64'(sh), 64'h0);
                        end else begin
                            chk(sh == exp_w[g][rd_p[g] % 512] && nb == 16, "word",
                                {32'(nb), 16'h0, sh}, {32'd16, 16'h0, exp_w[g][rd_p[g] % 512]});
                            rd_p[g]++;
                        end
                        if (sh[15:8] == 8'h01) fstart = fall_c;
                    end
                    if (done_s[g]) begin
                        done_cnt[g]++;
                        chk(cyc - fstart == 272*D, "done_time", 64'(cyc - fstart), 64'(272*D));
                    end
                    pcs = csn_s[g];
                    psclk = sclk_s[g];
                end
            end
        end
    end

    task automatic pulse(input int d);
        @(posedge clk); #1 upd_d[d] = 1'b1;
        @(posedge clk); #1 upd_d[d] = 1'b0;
    endtask

    task automatic measure_busy(input int d, input int expv);
        int n, w;
        n = 0; w = 0;
        do begin @(negedge clk); w++; end while (!busy_s[d] && w < 50);
        while (busy_s[d] && n < 6000) begin n++; @(negedge clk); end
        chk(n == expv, "busy_len", 64'(n), 64'(expv));
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while (busy_s[d] && w < 6000) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        chk(!busy_s[d], "idle_timeout", 64'(busy_s[d]), 64'h0);
        chk(rd_p[d] == wr_p[d], "words_outstanding", 64'(wr_p[d] - rd_p[d]), 64'h0);
        chk(done_cnt[d] == exp_done[d], "done_count", 64'(done_cnt[d]), 64'(exp_done[d]));
    endtask

    task automatic start_frame(input int d, input logic [63:0] g);
        grid_d[d] = g;
        push_frame(d, g);
        exp_done[d]++;
        pulse(d);
    endtask

    // Caller positions time just after a posedge; reset lands between clock edges.
    task automatic do_reset(input int d, input bit early, input logic [63:0] g);
        int dv;
        dv = (d == 0) ? 4 : 1;
        #2 rst_n_d[d] = 1'b0;
        upd_d[d] = 1'b0;
        #1;
        chk(csn_s[d] == 1'b1, "rst_async_cs_n", 64'(csn_s[d]), 64'h1);
        chk(sclk_s[d] == 1'b0, "rst_async_sclk", 64'(sclk_s[d]), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk({mosi_s[d], busy_s[d], done_s[d]} == 3'b000, "rst_mosi_busy_done",
            64'({mosi_s[d], busy_s[d], done_s[d]}), 64'h0);
        rd_p[d] = wr_p[d];
        push_init(d);
        if (early) begin
            push_frame(d, g);
            exp_done[d]++;
        end
        @(posedge clk); #1 rst_n_d[d] = 1'b1;
        if (early) begin
            fork
                measure_busy(d, (170 + 272) * dv);
                begin
                    repeat (10) @(posedge clk);
                    grid_d[d] = g;
                    pulse(d);
                end
            join
        end else begin
            measure_busy(d, 170 * dv);
        end
        wait_idle(d);
    endtask

    initial begin
        logic [63:0] g1, g2;
        grid_d[0] = 64'h0;
        grid_d[1] = 64'h0;
        for (int i = 0; i < 2; i++) begin
            wr_p[i] = 0; rd_p[i] = 0; done_cnt[i] = 0; exp_done[i] = 0;
        end

        for (int d = 0; d < 2; d++) begin
            int dv;
            dv = (d == 0) ? 4 : 1;

            @(posedge clk);
            do_reset(d, 1'b0, 64'h0);

            start_frame(d, 64'h1);
            measure_busy(d, 272 * dv);
            wait_idle(d);

            start_frame(d, 64'h8000_0000_0000_00FF);
            repeat (100 * dv) @(posedge clk);
            grid_d[d] = {$urandom, $urandom};
            wait_idle(d);

            for (int k = 0; k < 3; k++) begin
                start_frame(d, {$urandom, $urandom});
                wait_idle(d);
            end

            // Three updates during a frame chain exactly one more frame.
            g1 = {$urandom, $urandom};
            g2 = {$urandom, $urandom};
            start_frame(d, g1);
            fork
                measure_busy(d, 544 * dv);
                begin
                    repeat (50 * dv) @(posedge clk);
                    grid_d[d] = g2;
                    push_frame(d, g2);
                    exp_done[d]++;
                    for (int k = 0; k < 3; k++) begin
                        pulse(d);
                        repeat (5) @(posedge clk);
                    end
                end
            join
            wait_idle(d);

            @(posedge clk);
            do_reset(d, 1'b1, {$urandom, $urandom});

            // Reset while bit 7 of the fourth row word is being clocked out.
            g1 = {$urandom, $urandom};
            grid_d[d] = g1;
            push_frame(d, g1);
            pulse(d);
            repeat (119 * dv) @(posedge clk);
            #1;
            chk(csn_s[d] == 1'b0 && sclk_s[d] == 1'b1, "pre_reset_midword",
                64'({csn_s[d], sclk_s[d]}), 64'h1);
            do_reset(d, 1'b0, 64'h0);

            start_frame(d, {$urandom, $urandom});
            wait_idle(d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        chk(1'b0, "global_timeout", 64'(cyc), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grid_display_tx.md
Name: grid_display_tx

Overview:
Serial display transmitter that consumes the 64-bit Game of Life grid and drives an 8x8 LED matrix through a MAX7219-style 3-wire interface (sclk/mosi/cs_n).
- After reset it sends a fixed 5-word init sequence.
- Each `update` request then snapshots the grid and sends it as 8 row-data words.
- It sits downstream of the grid datapath, between the `grid` register and the board's display pins.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range 1..255
INTENSITY, 4'h8, value sent in the intensity-register init word

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
grid  input  64  cell state; bit r*8+c = row r, column c; 1 = alive
update  input  1  single-cycle request to display the current grid
busy  output  1  high while init or a frame is in progress
frame_done  output  1  one-cycle pulse when the last row word of a frame completes
sclk  output  1  serial clock, idles low
mosi  output  1  serial data, MSB first
cs_n  output  1  chip select/load, active low, idles high

Behaviour:
- Reset (async, rst_n=0): cs_n=1, sclk=0, mosi=0, busy=0, frame_done=0; pending flag cleared; FSM to INIT. Reset mid-word aborts immediately; no partial completion.
- Init sequence:
  - First rising clk edge after rst_n deasserts: busy=1 and init word 0 starts.
  - Words, in order: 16'h0C01 (shutdown off), 16'h0B07 (scan all 8 rows), 16'h0900 (no decode), {12'h0A0, INTENSITY}, 16'h0F00 (test off).
  - FSM then goes to IDLE with busy=0. No frame_done for init.
- Frame:
  - In IDLE, update=1 latches grid into an internal 64-bit snapshot and starts the frame; busy=1 from the next cycle.
  - Rows r=0..7 are sent in order as word {4'h0, r+1 (4 bits), data[7:0]}.
  - data[7-c] = snapshot[r*8+c], so column 0 goes out as the data MSB.
  - grid changes after the snapshot have no effect on the frame in flight.
- Word timing, starting at cycle T:
  - At T: cs_n=0, mosi=bit15, sclk=0.
  - For bit k (k=15..0): sclk rises at T+(31-2k)*CLK_DIV; sclk falls and mosi updates to bit k-1 at T+(32-2k)*CLK_DIV.
  - At T+32*CLK_DIV: sclk=0, cs_n=1, mosi=0.
  - cs_n stays high for 2*CLK_DIV cycles; the next word starts at T+34*CLK_DIV.
  - mosi is stable for CLK_DIV cycles on each side of every sclk rising edge.
- Frame completion: in the cycle the 8th word's cs_n-high gap ends (T0+272*CLK_DIV), frame_done=1 for one cycle and busy=0, unless a pending request exists.
- Pending request (one deep):
  - update while busy (init or frame) sets pending; further updates while pending is set are absorbed.
  - When init or a frame ends with pending set: clear pending, snapshot grid in that cycle, and start a new frame with no IDLE cycle; busy stays 1.
  - frame_done still pulses for the completed frame.
- Counters:
  - Divider: 8 bits, counts 0..CLK_DIV-1.
  - Bit counter: 5 bits, counts half-periods 0..31.
  - Word index: 3 bits; init uses 0..4, frame uses 0..7.
  - Gap counter: reuses the divider.
  - All counters wrap only under FSM control; no free-running wrap.
- FSM states: INIT_SHIFT, INIT_GAP, IDLE, FRAME_SHIFT, FRAME_GAP.
  - SHIFT goes to GAP after 32 half-periods.
  - GAP goes to the next SHIFT, or to IDLE/next frame, after 2*CLK_DIV cycles.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset release, CLK_DIV=4, INTENSITY=8. SPI monitor samples on sclk rise and collects a word per cs_n rise. Expect words 0C01, 0B07, 0900, 0A08, 0F00; busy high for 680 cycles, then low.
2. grid=64'h1, update pulse. Expect words 0180, 0200, 0300, 0400, 0500, 0600, 0700, 0800. frame_done pulses exactly 1088 cycles after the first cs_n fall; cs_n low for 128 cycles per word.
3. grid=64'h8000_0000_0000_00FF. Expect row1 word 01FF, row8 word 0801, all other rows x00. Change grid mid-frame: the transmitted words are unchanged.
4. Pulse update three times during a frame. Expect exactly one back-to-back second frame: no IDLE cycle, busy continuous, frame_done pulses twice. An update during init yields one frame right after init.
5. Assert rst_n low mid-word (bit 7 of row 3). Expect cs_n=1 and sclk=0 asynchronously, before the next clk edge. After release, the full init sequence restarts and no frame_done is produced.
6. CLK_DIV=1. Expect sclk period of 2 clk cycles, word period of 34 cycles, frame of 272 cycles; data identical to test 2.
